keypad_entry_ctrl: RTL and testbench
====================================

# keypad_entry_ctrl

Sequencer that sits behind the 4x4 matrix-keypad scanner and turns its raw key code and key-down level into debounced, single-shot key events. It interprets those events as a 4-digit decimal entry buffer with enter, backspace and clear commands, plus an idle timeout. Downstream logic, such as a lock comparator or display driver, receives a completed 4-digit code with a one-cycle valid strobe. Keys 0–9 are digits. A is enter, B is backspace, C is clear. D, E and F are ignored.

## Interface
Parameters:
- DEB_CYCLES, 1_000_000: key_down must be stable for this many cycles before a press or release is accepted (20 ms at 50 MHz). Minimum 2.
- TIMEOUT_CYCLES, 250_000_000: number of idle cycles with a non-empty buffer before the buffer auto-clears (5 s). Minimum 2.

Ports:
- sys_clk, input, 1: system clock, 50 MHz.
- rst_n, input, 1: reset. One clock; reset is asynchronous and active-low.
- key_code, input, 4: key value from the scanner, synchronous to sys_clk.
- key_down, input, 1: level, high while the scanner reports a pressed key. Synchronous to sys_clk.
- digits, output, 16: entry buffer, 4 BCD nibbles; [3:0] holds the most recent digit.
- digit_cnt, output, 3: number of valid digits, 0–4.
- code, output, 16: last accepted 4-digit code. Holds its value until the next accept.
- code_valid, output, 1: one-cycle pulse when code updates.
- err, output, 1: one-cycle pulse on a rejected digit or a rejected enter.
- timeout, output, 1: one-cycle pulse when the buffer auto-clears.
- busy, output, 1: high whenever the debounce FSM is not in IDLE.

## Operation
Debounce FSM, with one counter of width $clog2(DEB_CYCLES):
- IDLE: key_down=1 → go to PRESS_WAIT and set the counter to 1.
- PRESS_WAIT:
  - key_down=0 → go to IDLE with no event.
  - counter==DEB_CYCLES-1 with key_down=1 → go to HELD, latch key_code and execute the key action on this edge.
  - otherwise increment the counter.
- HELD: key_down=0 → go to RELEASE_WAIT and set the counter to 1. Holding a key never repeats the action.
- RELEASE_WAIT:
  - key_down=1 → go back to HELD.
  - counter==DEB_CYCLES-1 with key_down=0 → go to IDLE.
- Default or illegal state → IDLE.

Key actions, executed on the accept edge:
- Digit 0–9:
  - digit_cnt<4: digits←{digits[11:0],key}, digit_cnt+1.
  - digit_cnt==4: err pulse, buffer unchanged.
- A (enter):
  - digit_cnt==4: code←digits, code_valid pulse, digits←0, digit_cnt←0.
  - digit_cnt<4: err pulse, buffer unchanged.
- B (backspace):
  - digit_cnt>0: digits←{4'h0,digits[15:4]}, digit_cnt−1.
  - digit_cnt==0: no-op, no err.
- C (clear): digits←0, digit_cnt←0. No pulse.
- D, E, F: no effect, no err.

Idle timeout, with a counter of width $clog2(TIMEOUT_CYCLES):
- The counter is held at 0 while digit_cnt==0 and is cleared on every accept edge.
- It increments on every other cycle.
- When it reaches TIMEOUT_CYCLES-1: clear the buffer, pulse timeout, and reset the counter to 0.

## Timing
Reset values:
- All outputs are 0.
- The FSM is in IDLE.
- Both counters are 0.
- The latched key is 0.

Latency:
- Let E0 be the first edge at which key_down is sampled high from IDLE.
- The accept edge is E0+DEB_CYCLES−1, provided key_down is sampled high at every edge from E0 through the accept edge.
- The updated digits, digit_cnt and code, and the pulses, are visible in the cycle after the accept edge.
- A new press is accepted no earlier than 2·DEB_CYCLES−1 edges after the previous accept edge, counting the release debounce.

Pulses:
- code_valid, err and timeout are exactly one cycle wide.
- At most one of them is asserted in any cycle.

Boundary cases:
- A glitch shorter than DEB_CYCLES during PRESS_WAIT produces no event.
- A glitch during RELEASE_WAIT returns the FSM to HELD with no new event.
- Timeout expiry and an accept edge in the same cycle: the key action wins, no timeout pulse is produced, and the timeout counter clears.
- A rejected action (err) still clears the timeout counter.
- Asserting rst_n low mid-debounce or mid-entry immediately clears all state. Outputs, including code, return to 0 asynchronously.
- key_code changing after the accept edge has no effect.

## Test plan
Bench parameters: DEB_CYCLES=4, TIMEOUT_CYCLES=50.
- Press 1,2,3,4 then A, each held 10 cycles with 10-cycle gaps → digit_cnt steps 1 to 4 and digits ends at 16'h1234. After A: code=16'h1234, one code_valid pulse, digits=0, digit_cnt=0.
- key_down pulses of 2 cycles, and 3 cycles, with key_code=5 → no event, digit_cnt stays 0, busy returns low. A 4-cycle hold → digits=16'h0005.
- Enter 9,8 then B, then A → after B: digits=16'h0009, digit_cnt=1. A produces one err pulse and digits is unchanged.
- Five digits 1..5 → the fifth produces an err pulse and digits stays 16'h1234. Then C → digits=0, digit_cnt=0, no pulse.
- Enter 7 then stay idle → timeout pulse exactly 50 cycles after the accept edge and buffer cleared. A press whose accept edge falls on the expiry cycle → no timeout pulse, and the digit is appended.
- Assert rst_n low during PRESS_WAIT and again with digit_cnt=3 → all outputs are 0 immediately. After release, a fresh 4-cycle press is accepted normally.

Source files
------------

// File: rtl/keypad_entry_if.sv
// Keypad entry bundle: scanner-side key inputs and the entry-buffer results.
//   key_code   : 4-bit key value from the matrix scanner
//   key_down   : high while the scanner reports a pressed key
//   digits     : entry buffer, 4 BCD nibbles, [3:0] is the most recent digit
//   digit_cnt  : number of valid digits, 0..4
//   code       : last accepted 4-digit code
//   code_valid : one-cycle strobe when code updates
//   err        : one-cycle strobe on a rejected digit or enter
//   timeout    : one-cycle strobe when the buffer auto-clears
//   busy       : debounce FSM is not idle
// master drives the key inputs and observes results; slave is the controller.
interface keypad_entry_if;
    logic [3:0]  key_code;
    logic        key_down;
    logic [15:0] digits;
    logic [2:0]  digit_cnt;
    logic [15:0] code;
    logic        code_valid;
    logic        err;
    logic        timeout;
    logic        busy;

    modport master (
        output key_code, key_down,
        input  digits, digit_cnt, code, code_valid, err, timeout, busy
    );

    modport slave (
        input  key_code, key_down,
        output digits, digit_cnt, code, code_valid, err, timeout, busy
    );
endinterface

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: debounces the scanner's key_down level into single-shot
// key events and runs a 4-digit decimal entry buffer with enter (A), backspace (B),
// clear (C) and an idle auto-clear. D/E/F are ignored.
// Ports:
//   sys_clk : system clock
//   rst_n   : asynchronous active-low reset
//   kp      : keypad_entry_if.slave bundle (key inputs, buffer/code/strobes/busy)
module keypad_entry_ctrl #(
    parameter int unsigned DEB_CYCLES     = 1_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 250_000_000
) (
    input  logic          sys_clk,
    input  logic          rst_n,
    keypad_entry_if.slave kp
);
    localparam int unsigned DW = $clog2(DEB_CYCLES);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StPressWait, StHeld, StReleaseWait} state_e;

    state_e        state_q;
    logic [DW-1:0] deb_cnt_q;
    logic [TW-1:0] to_cnt_q;
    logic [15:0]   digits_q;
    logic [2:0]    digit_cnt_q;
    logic [15:0]   code_q;
    logic          code_valid_q;
    logic          err_q;
    logic          timeout_q;
    logic          accept;

    // The key action is taken on this edge straight from key_code, so later
    // key_code changes cannot affect it.
    assign accept = (state_q == StPressWait) && kp.key_down && (deb_cnt_q == DEB_LAST);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            deb_cnt_q    <= '0;
            to_cnt_q     <= '0;
            digits_q     <= '0;
            digit_cnt_q  <= '0;
            code_q       <= '0;
            code_valid_q <= 1'b0;
            err_q        <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            code_valid_q <= 1'b0;
            err_q        <= 1'b0;
            timeout_q    <= 1'b0;

            case (state_q)
                StIdle: begin
                    if (kp.key_down) begin
                        state_q   <= StPressWait;
                        deb_cnt_q <= DW'(1);
                    end
                end
                StPressWait: begin
                    if (!kp.key_down) begin
                        state_q <= StIdle;
                    end else if (accept) begin
                        state_q <= StHeld;
                    end else begin
                        deb_cnt_q <= deb_cnt_q + DW'(1);
                    end
                end
                StHeld: begin
                    if (!kp.key_down) begin
                        state_q   <= StReleaseWait;
                        deb_cnt_q <= DW'(1);
                    end
                end
                StReleaseWait: begin
                    if (kp.key_down) begin
                        state_q <= StHeld;
                    end else if (deb_cnt_q == DEB_LAST) begin
                        state_q <= StIdle;
                    end else begin
                        deb_cnt_q <= deb_cnt_q + DW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase

            // An accept edge always beats a coinciding timeout expiry.
            if (accept) begin
                to_cnt_q <= '0;
                if (kp.key_code <= 4'd9) begin
                    if (digit_cnt_q != 3'd4) begin
                        digits_q    <= {digits_q[11:0], kp.key_code};
                        digit_cnt_q <= digit_cnt_q + 3'd1;
                    end else begin
                        err_q <= 1'b1;
                    end
                end else if (kp.key_code == 4'hA) begin
                    if (digit_cnt_q == 3'd4) begin
                        code_q       <= digits_q;
                        code_valid_q <= 1'b1;
                        digits_q     <= '0;
                        digit_cnt_q  <= '0;
                    end else begin
                        err_q <= 1'b1;
                    end
                end else if (kp.key_code == 4'hB) begin
                    if (digit_cnt_q != 3'd0) begin
                        digits_q    <= {4'h0, digits_q[15:4]};
                        digit_cnt_q <= digit_cnt_q - 3'd1;
                    end
                end else if (kp.key_code == 4'hC) begin
                    digits_q    <= '0;
                    digit_cnt_q <= '0;
                end
            end else if (digit_cnt_q == 3'd0) begin
                to_cnt_q <= '0;
            end else if (to_cnt_q == TO_LAST) begin
                digits_q    <= '0;
                digit_cnt_q <= '0;
                timeout_q   <= 1'b1;
                to_cnt_q    <= '0;
            end else begin
                to_cnt_q <= to_cnt_q + TW'(1);
            end
        end
    end

    assign kp.digits     = digits_q;
    assign kp.digit_cnt  = digit_cnt_q;
    assign kp.code       = code_q;
    assign kp.code_valid = code_valid_q;
    assign kp.err        = err_q;
    assign kp.timeout    = timeout_q;
    assign kp.busy       = (state_q != StIdle);
endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Bench for keypad_entry_ctrl with DEB_CYCLES=4, TIMEOUT_CYCLES=50. A reference
// model tracks debounce as runs of equal key_down samples and the entry buffer as
// a queue of digits; every cycle is compared, plus directed checks per scenario.
module tb_keypad_entry_ctrl;
    localparam int DEB = 4;
    localparam int TO  = 50;

    logic sys_clk;
    logic rst_n;
    keypad_entry_if kp();

    keypad_entry_ctrl #(
        .DEB_CYCLES    (DEB),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .sys_clk(sys_clk),
        .rst_n  (rst_n),
        .kp     (kp)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int cyc_bad = 0;
    int n_cv = 0;
    int n_err = 0;
    int n_to = 0;
    int last_to_cyc = -1;

    // Reference model state
    int          m_q[$];      // buffered digits, oldest first
    logic [15:0] m_code;
    bit          m_armed;     // ready to detect a new press
    int          m_hi;
    int          m_lo;
    int          m_idle;
    bit          m_cv;
    bit          m_err;
    bit          m_to;

    function automatic logic [15:0] q_val();
        logic [15:0] v = '0;
        foreach (m_q[i]) v = (v << 4) | 16'(m_q[i]);
        return v;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_code  = '0;
        m_armed = 1'b1;
        m_hi    = 0;
        m_lo    = 0;
        m_idle  = 0;
        m_cv    = 1'b0;
        m_err   = 1'b0;
        m_to    = 1'b0;
    endtask

    task automatic model_edge(input logic kd, input logic [3:0] kc);
        bit acc = 1'b0;
        m_cv  = 1'b0;
        m_err = 1'b0;
        m_to  = 1'b0;
        if (m_armed) begin
            if (kd) begin
                m_hi++;
                if (m_hi == DEB) begin
                    acc     = 1'b1;
                    m_armed = 1'b0;
                    m_lo    = 0;
                end
            end else begin
                m_hi = 0;
            end
        end else begin
            if (!kd) begin
                m_lo++;
                if (m_lo == DEB) begin
                    m_armed = 1'b1;
                    m_hi    = 0;
                end
            end else begin
                m_lo = 0;
            end
        end
        if (acc) begin
            m_idle = 0;
            if (kc <= 4'd9) begin
                if (m_q.size() < 4) m_q.push_back(int'(kc));
                else m_err = 1'b1;
            end else if (kc == 4'hA) begin
                if (m_q.size() == 4) begin
                    m_code = q_val();
                    m_cv   = 1'b1;
                    m_q.delete();
                end else begin
                    m_err = 1'b1;
                end
            end else if (kc == 4'hB) begin
                if (m_q.size() > 0) void'(m_q.pop_back());
            end else if (kc == 4'hC) begin
                m_q.delete();
            end
        end else if (m_q.size() == 0) begin
            m_idle = 0;
        end else begin
            m_idle++;
            if (m_idle == TO) begin
                m_q.delete();
                m_to   = 1'b1;
                m_idle = 0;
            end
        end
    endtask

    // One clock: drive inputs, advance the model on the edge, sample 1 ns later.
    task automatic step(input logic kd, input logic [3:0] kc);
        kp.key_down = kd;
        kp.key_code = kc;
        @(posedge sys_clk);
        cyc++;
        model_edge(kd, kc);
        #1;
        if (kp.digits !== q_val() || kp.digit_cnt !== 3'(m_q.size()) ||
            kp.code !== m_code || kp.busy !== !(m_armed && m_hi == 0) ||
            kp.code_valid !== m_cv || kp.err !== m_err || kp.timeout !== m_to)
            cyc_bad++;
        if (kp.code_valid) n_cv++;
        if (kp.err) n_err++;
        if (kp.timeout) begin
            n_to++;
            last_to_cyc = cyc;
        end
    endtask

    task automatic press(input logic [3:0] kc, input int hold, input int gap);
        for (int i = 0; i < hold; i++) step(1'b1, (i >= DEB) ? 4'($urandom) : kc);
        for (int i = 0; i < gap; i++) step(1'b0, kc);
    endtask

    task automatic check_tracking(input string tag);
        n_cmp++;
        if (cyc_bad !== 0) begin
            n_fail++;
            $display("FAIL %s model_tracking: %0d bad cycles, required 0", tag, cyc_bad);
        end
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        kp.key_down = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (kp.digits !== 16'h0) begin
            n_fail++; $display("FAIL %s digits: got %h required 0000", tag, kp.digits);
        end
        n_cmp++;
        if (kp.digit_cnt !== 3'd0) begin
            n_fail++; $display("FAIL %s digit_cnt: got %0d required 0", tag, kp.digit_cnt);
        end
        n_cmp++;
        if (kp.code !== 16'h0) begin
            n_fail++; $display("FAIL %s code: got %h required 0000", tag, kp.code);
        end
        n_cmp++;
        if ({kp.code_valid, kp.err, kp.timeout, kp.busy} !== 4'b0) begin
            n_fail++;
            $display("FAIL %s strobes_busy: got %b required 0000", tag,
                     {kp.code_valid, kp.err, kp.timeout, kp.busy});
        end
        @(negedge sys_clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        async_reset("reset");
        for (int i = 0; i < 3; i++) step(1'b0, 4'h0);
        n_cmp++;
        if ({kp.digits, kp.digit_cnt, kp.code, kp.busy} !== '0) begin
            n_fail++; $display("FAIL reset_after_release: got nonzero outputs, required 0");
        end
        check_tracking("reset");
    endtask

    task automatic test_entry();
        logic [3:0] keys [4] = '{4'h1, 4'h2, 4'h3, 4'h4};
        int cv0 = n_cv;
        for (int i = 0; i < 4; i++) begin
            press(keys[i], 10, 10);
            n_cmp++;
            if (kp.digit_cnt !== 3'(i + 1)) begin
                n_fail++;
                $display("FAIL entry_cnt: got %0d required %0d", kp.digit_cnt, i + 1);
            end
        end
        n_cmp++;
        if (kp.digits !== 16'h1234) begin
            n_fail++; $display("FAIL entry_digits: got %h required 1234", kp.digits);
        end
        press(4'hA, 10, 10);
        n_cmp++;
        if (kp.code !== 16'h1234) begin
            n_fail++; $display("FAIL enter_code: got %h required 1234", kp.code);
        end
        n_cmp++;
        if (n_cv - cv0 !== 1) begin
            n_fail++; $display("FAIL enter_pulses: got %0d required 1", n_cv - cv0);
        end
        n_cmp++;
        if ({kp.digits, kp.digit_cnt} !== '0) begin
            n_fail++;
            $display("FAIL enter_clear: got %h/%0d required 0000/0", kp.digits, kp.digit_cnt);
        end
        check_tracking("entry");
    endtask

    task automatic test_glitch();
        press(4'h5, 2, 3);
        press(4'h5, 3, 3);
        n_cmp++;
        if (kp.digit_cnt !== 3'd0 || kp.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch: got cnt %0d busy %b required 0 0", kp.digit_cnt, kp.busy);
        end
        press(4'h5, DEB, 10);
        n_cmp++;
        if (kp.digits !== 16'h0005) begin
            n_fail++; $display("FAIL glitch_press: got %h required 0005", kp.digits);
        end
        press(4'hC, 10, 10);
        check_tracking("glitch");
    endtask

    task automatic test_backspace();
        int err0;
        press(4'h9, 10, 10);
        press(4'h8, 10, 10);
        press(4'hB, 10, 10);
        n_cmp++;
        if (kp.digits !== 16'h0009 || kp.digit_cnt !== 3'd1) begin
            n_fail++;
            $display("FAIL backspace: got %h/%0d required 0009/1", kp.digits, kp.digit_cnt);
        end
        err0 = n_err;
        press(4'hA, 10, 10);
        n_cmp++;
        if (n_err - err0 !== 1 || kp.digits !== 16'h0009) begin
            n_fail++;
            $display("FAIL short_enter: got err %0d digits %h required 1 0009",
                     n_err - err0, kp.digits);
        end
        check_tracking("backspace");
    endtask

    task automatic test_overflow_clear();
        int err0;
        int p0;
        press(4'hC, 10, 10);
        err0 = n_err;
        for (int i = 1; i <= 5; i++) press(4'(i), 10, 10);
        n_cmp++;
        if (n_err - err0 !== 1 || kp.digits !== 16'h1234) begin
            n_fail++;
            $display("FAIL overflow: got err %0d digits %h required 1 1234",
                     n_err - err0, kp.digits);
        end
        p0 = n_cv + n_err + n_to;
        press(4'hC, 10, 10);
        n_cmp++;
        if ({kp.digits, kp.digit_cnt} !== '0 || n_cv + n_err + n_to - p0 !== 0) begin
            n_fail++;
            $display("FAIL clear: got %h/%0d pulses %0d required 0000/0 0",
                     kp.digits, kp.digit_cnt, n_cv + n_err + n_to - p0);
        end
        check_tracking("overflow");
    endtask

    task automatic test_timeout();
        int to0 = n_to;
        int acc;
        for (int i = 0; i < DEB; i++) step(1'b1, 4'h7);
        acc = cyc;
        n_cmp++;
        if (kp.digits !== 16'h0007) begin
            n_fail++; $display("FAIL timeout_entry: got %h required 0007", kp.digits);
        end
        for (int i = 0; i < 60; i++) step(1'b0, 4'h7);
        n_cmp++;
        if (n_to - to0 !== 1 || last_to_cyc - acc !== TO) begin
            n_fail++;
            $display("FAIL timeout_pulse: got %0d pulses at +%0d required 1 at +%0d",
                     n_to - to0, last_to_cyc - acc, TO);
        end
        n_cmp++;
        if ({kp.digits, kp.digit_cnt} !== '0) begin
            n_fail++; $display("FAIL timeout_clear: got %h required 0000", kp.digits);
        end
        // Second press lands its accept edge exactly on the expiry edge.
        to0 = n_to;
        for (int i = 0; i < DEB; i++) step(1'b1, 4'h7);
        for (int i = 0; i < TO - DEB; i++) step(1'b0, 4'h7);
        for (int i = 0; i < DEB; i++) step(1'b1, 4'h7);
        n_cmp++;
        if (kp.digits !== 16'h0077 || kp.digit_cnt !== 3'd2 || n_to - to0 !== 0) begin
            n_fail++;
            $display("FAIL timeout_collide: got %h/%0d pulses %0d required 0077/2 0",
                     kp.digits, kp.digit_cnt, n_to - to0);
        end
        for (int i = 0; i < DEB + 2; i++) step(1'b0, 4'h0);
        check_tracking("timeout");
    endtask

    task automatic test_reset_mid();
        step(1'b1, 4'h3);
        step(1'b1, 4'h3);
        n_cmp++;
        if (kp.busy !== 1'b1) begin
            n_fail++; $display("FAIL press_wait_busy: got %b required 1", kp.busy);
        end
        async_reset("reset_press_wait");
        for (int i = 1; i <= 4; i++) press(4'(i), 5, 5);
        press(4'hA, 5, 5);
        for (int i = 1; i <= 3; i++) press(4'(i), 5, 5);
        n_cmp++;
        if (kp.digit_cnt !== 3'd3 || kp.code !== 16'h1234) begin
            n_fail++;
            $display("FAIL pre_reset: got cnt %0d code %h required 3 1234",
                     kp.digit_cnt, kp.code);
        end
        async_reset("reset_entry");
        press(4'h6, DEB, 6);
        n_cmp++;
        if (kp.digits !== 16'h0006 || kp.digit_cnt !== 3'd1) begin
            n_fail++;
            $display("FAIL post_reset_press: got %h/%0d required 0006/1",
                     kp.digits, kp.digit_cnt);
        end
        check_tracking("reset_mid");
    endtask

    task automatic test_random();
        int hold;
        int gap;
        for (int n = 0; n < 60; n++) begin
            hold = int'($urandom_range(1, DEB + 6));
            gap  = ($urandom_range(0, 5) == 0) ? 60 : int'($urandom_range(1, 12));
            press(4'($urandom_range(0, 15)), hold, gap);
        end
        n_cmp++;
        if (kp.digits !== q_val() || kp.code !== m_code) begin
            n_fail++;
            $display("FAIL random_final: got %h/%h required %h/%h",
                     kp.digits, kp.code, q_val(), m_code);
        end
        check_tracking("random");
    endtask

    initial begin
        rst_n = 1'b0;
        kp.key_down = 1'b0;
        kp.key_code = 4'h0;
        model_reset();
        test_reset();
        test_entry();
        test_glitch();
        test_backspace();
        test_overflow_clear();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
